shift_register_univ: RTL
========================

Name: shift_register_univ

Overview:
- Parametrised universal shift register; next generation of the team's 8-bit load/shift register.
- Adds configurable width, three shift modes (logical, rotate, arithmetic), and serial in/out.
- Adds a counted burst shift with busy/done handshake so a controller can request N shifts in one command.
- Serves as a datapath building block for serialisers, bit-manipulation and simple multiply/divide sequencers.

Parameters:
WIDTH, 8, register width in bits (min 2)
CNT_W, $clog2(WIDTH)+1, width of burst count input (must hold WIDTH)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous reset, active-low
load  input  1  parallel load of in into register
shift_en  input  1  single-step shift this cycle
dir  input  1  0 = left (toward MSB), 1 = right (toward LSB)
mode  input  2  0 logical, 1 rotate, 2 arithmetic, 3 reserved (treated as logical)
ser_in  input  1  fill bit for logical shifts
start  input  1  begin burst shift of count steps
count  input  CNT_W  number of burst steps, sampled with start
in  input  WIDTH  parallel load data
out  output  WIDTH  register contents (registered)
ser_out  output  1  last bit shifted out (registered)
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-low: when reset=0 at a rising edge, out=0, ser_out=0, busy=0, done=0, and the step counter is cleared. Reset overrides every other input, including mid-burst.
- Priority per edge: reset > load > start (idle only) > burst step (busy) > shift_en (idle only) > hold.
- Step function for one shift:
  - Left logical: out <= {out[WIDTH-2:0], ser_in}; ser_out <= out[WIDTH-1].
  - Right logical: out <= {ser_in, out[WIDTH-1:1]}; ser_out <= out[0].
  - Left rotate: out <= {out[WIDTH-2:0], out[WIDTH-1]}. Right rotate: out <= {out[0], out[WIDTH-1:1]}. ser_out takes the bit that wrapped.
  - Arithmetic right: MSB replicated. Arithmetic left: fills 0, ignoring ser_in. ser_out as for logical.
  - mode 3 behaves exactly as mode 0.
- Load: out <= in; ser_out unchanged. A load while busy aborts the burst: busy->0, counter cleared, no done pulse.
- State machine, IDLE/BUSY:
  - IDLE + start with count=N>0: latch N into the remaining counter, move to BUSY, busy=1. No shift on the start edge.
  - IDLE + start with count=0: stay IDLE; done=1 on the next cycle; no shift.
  - BUSY: each edge performs one step using the current dir/mode/ser_in and decrements the counter. On the edge performing the final step, go to IDLE, busy->0, done->1 for exactly one cycle, coincident with the final out value.
  - busy is high for exactly N cycles. N > WIDTH is legal and keeps shifting (rotate wraps repeatedly).
- While busy, start and shift_en are ignored.
- done is otherwise 0. A new start is accepted in the cycle where done=1, since the block is back in IDLE.
- Simultaneous load and shift_en: load wins, no shift.

Decomposition:
- Package shift_pkg:
  - mode encodings MODE_LOGIC=2'd0, MODE_ROT=2'd1, MODE_ARITH=2'd2
  - direction constants DIR_LEFT=1'b0, DIR_RIGHT=1'b1
  - state encodings ST_IDLE, ST_BUSY
- Sub-module shift_step: combinational one-step shifter, parametrised by WIDTH, with inputs din, dir, mode, ser_in and outputs dout, bit_out. Instantiated once and shared by the single-step and burst paths.

Test Plan:
- reset=0 for 1 cycle with load=1, in=8'hFF -> out=8'h00, busy=0, done=0 (reset beats load).
- load 8'hA5; then shift_en=1, dir=0, mode=0, ser_in=0 for 1 cycle -> out=8'h4A, ser_out=1. Then dir=1, ser_in=1 for 1 cycle -> out=8'hA5, ser_out=0.
- load 8'h81; start, count=3, mode=1, dir=1 -> busy high 3 cycles, out C0,60,30, done pulse with out=8'h30, ser_out=0.
- load 8'h90; start, count=2, mode=2, dir=1 -> out C8 then E4, done pulse. Then start, count=0 -> done next cycle, out stays 8'hE4, busy never asserts.
- Burst abort: start, count=5, mode=0; after 2 steps assert load with in=8'h3C -> out=8'h3C, busy=0, no done pulse; start and shift_en asserted during busy have no effect.
- reset=0 mid-burst (count=6, after 3 steps) -> next edge out=0, busy=0, done=0, and a following start is accepted normally.

Source files
------------

// File: rtl/shift_register_univ_pkg.sv
// Shared encodings for the universal shift register: shift modes, directions, FSM states.
package shift_pkg;

  localparam logic [1:0] MODE_LOGIC = 2'd0;
  localparam logic [1:0] MODE_ROT   = 2'd1;
  localparam logic [1:0] MODE_ARITH = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/shift_register_univ_step.sv
// Combinational one-step shifter: logical, rotate or arithmetic, either direction.
// Zero latency; no flow control.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] dout,
  output logic             bit_out
);

  always_comb begin
    dout    = din;
    bit_out = 1'b0;
    if (dir == DIR_LEFT) begin
      bit_out = din[WIDTH-1];
      case (mode)
        MODE_ROT:   dout = {din[WIDTH-2:0], din[WIDTH-1]};
        MODE_ARITH: dout = {din[WIDTH-2:0], 1'b0};
        default:    dout = {din[WIDTH-2:0], ser_in};
      endcase
    end else begin
      bit_out = din[0];
      case (mode)
        MODE_ROT:   dout = {din[0], din[WIDTH-1:1]};
        MODE_ARITH: dout = {din[WIDTH-1], din[WIDTH-1:1]};
        default:    dout = {ser_in, din[WIDTH-1:1]};
      endcase
    end
  end

endmodule

// File: rtl/shift_register_univ.sv
// Universal shift register with parallel load, single-step shift and counted burst shift.
// Outputs registered, one-cycle latency; start/shift_en are ignored while busy, load aborts a burst.
module shift_register_univ
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] out_d;
  logic             ser_d;
  logic             done_d;

  logic [WIDTH-1:0] step_dat;
  logic             step_bit;

  // Single shifter serves both the idle single-step and the burst path.
  shift_step #(.WIDTH(WIDTH)) u_step (
    .din     (out),
    .dir     (dir),
    .mode    (mode),
    .ser_in  (ser_in),
    .dout    (step_dat),
    .bit_out (step_bit)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    out_d   = out;
    ser_d   = ser_out;
    done_d  = 1'b0;
    if (load) begin
      out_d   = in;
      state_d = ST_IDLE;
      rem_d   = '0;
    end else if (state_q == ST_IDLE && start) begin
      if (count != '0) begin
        state_d = ST_BUSY;
        rem_d   = count;
      end else begin
        done_d = 1'b1;
      end
    end else if (state_q == ST_BUSY) begin
      out_d = step_dat;
      ser_d = step_bit;
      rem_d = rem_q - 1'b1;
      if (rem_q == CNT_W'(1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else if (shift_en) begin
      out_d = step_dat;
      ser_d = step_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      out     <= '0;
      ser_out <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      out     <= out_d;
      ser_out <= ser_d;
      done    <= done_d;
    end
  end

  assign busy = (state_q == ST_BUSY);

endmodule
